// File: rtl/inst_pipe_regs_if.sv
// Pipeline instruction-register bus: fetch word and hazard controls in,
// stage registers, hold/hazard flags and hazard statistics out.
interface inst_pipe_regs_if;
  logic [31:0] IF_Inst;
  logic        Branch_Taken;
  logic        Global_Stall;
  logic [31:0] PR_IFID_Inst;
  logic [31:0] PR_IDEX_Inst;
  logic [31:0] PR_EXMEM_Inst;
  logic [31:0] PR_MEMWB_Inst;
  logic        PC_Hold;
  logic        Load_Use;
  logic [15:0] Stall_Count;
  logic [15:0] Flush_Count;

  modport master (
    output IF_Inst, Branch_Taken, Global_Stall,
    input  PR_IFID_Inst, PR_IDEX_Inst, PR_EXMEM_Inst, PR_MEMWB_Inst,
    input  PC_Hold, Load_Use, Stall_Count, Flush_Count
  );

  modport slave (
    input  IF_Inst, Branch_Taken, Global_Stall,
    output PR_IFID_Inst, PR_IDEX_Inst, PR_EXMEM_Inst, PR_MEMWB_Inst,
    output PC_Hold, Load_Use, Stall_Count, Flush_Count
  );
endinterface

// File: rtl/inst_pipe_regs.sv
// Four-stage instruction pipeline registers with load-use stall and branch flush.
// Optional hazard statistics counters are built when HAZARD_STATS_EN is defined.
module inst_pipe_regs #(
  parameter logic [31:0] NOP_INST = 32'h00000000
) (
  input  logic             clock,
  input  logic             reset,
  inst_pipe_regs_if.slave  bus
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam int IFID  = 0;
  localparam int IDEX  = 1;
  localparam int EXMEM = 2;
  localparam int MEMWB = 3;

  typedef enum logic [1:0] {
    ACT_SHIFT,
    ACT_STALL,
    ACT_FLUSH,
    ACT_FREEZE
  } action_t;

  logic [31:0] stage_reg  [4];
  logic [31:0] stage_next [4];
  action_t     action;

  logic [5:0] ifid_op;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic [5:0] idex_op;
  logic [4:0] idex_rt;
  logic       rt_is_source;
  logic       load_use;

  assign ifid_op = stage_reg[IFID][31:26];
  assign ifid_rs = stage_reg[IFID][25:21];
  assign ifid_rt = stage_reg[IFID][20:16];
  assign idex_op = stage_reg[IDEX][31:26];
  assign idex_rt = stage_reg[IDEX][20:16];

  // Only R-type, BEQ and SW read rt; immediate ops write it instead.
  assign rt_is_source = (ifid_op == OP_SPECIAL) || (ifid_op == OP_BEQ) || (ifid_op == OP_SW);

  always_comb begin
    load_use = 1'b0;
    if ((idex_op == OP_LW) && (idex_rt != 5'd0)) begin
      load_use = (idex_rt == ifid_rs) || ((idex_rt == ifid_rt) && rt_is_source);
    end
  end

  always_comb begin
    action = ACT_SHIFT;
    if (bus.Global_Stall) begin
      action = ACT_FREEZE;
    end else if (bus.Branch_Taken) begin
      action = ACT_FLUSH;
    end else if (load_use) begin
      action = ACT_STALL;
    end
  end

  assign stage_next[IFID] = (action == ACT_FLUSH) ? NOP_INST :
                            (action == ACT_STALL) ? stage_reg[IFID] :
                                                    bus.IF_Inst;

  // Downstream stages take the previous stage unless squashed by a flush
  // (all but MEMWB, which retires the branch) or by the stall bubble (IDEX).
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_stage_next
      if (gi == MEMWB) begin : g_tail
        assign stage_next[gi] = stage_reg[gi-1];
      end else if (gi == IDEX) begin : g_bubble
        assign stage_next[gi] = ((action == ACT_FLUSH) || (action == ACT_STALL)) ?
                                NOP_INST : stage_reg[gi-1];
      end else begin : g_mid
        assign stage_next[gi] = (action == ACT_FLUSH) ? NOP_INST : stage_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        stage_reg[i] <= NOP_INST;
      end
    end else if (action != ACT_FREEZE) begin
      for (int i = 0; i < 4; i++) begin
        stage_reg[i] <= stage_next[i];
      end
    end
  end

  assign bus.PR_IFID_Inst  = stage_reg[IFID];
  assign bus.PR_IDEX_Inst  = stage_reg[IDEX];
  assign bus.PR_EXMEM_Inst = stage_reg[EXMEM];
  assign bus.PR_MEMWB_Inst = stage_reg[MEMWB];
  assign bus.Load_Use      = load_use;
  assign bus.PC_Hold       = bus.Global_Stall | (load_use & ~bus.Branch_Taken);

`ifdef HAZARD_STATS_EN
  // Index 0 counts stall edges, index 1 counts flush edges; both saturate.
  logic [15:0] cnt_reg [2];
  logic [1:0]  cnt_evt;

  assign cnt_evt = {action == ACT_FLUSH, action == ACT_STALL};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        cnt_reg[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cnt_evt[i] && (cnt_reg[i] != 16'hFFFF)) begin
          cnt_reg[i] <= cnt_reg[i] + 16'd1;
        end
      end
    end
  end

  assign bus.Stall_Count = cnt_reg[0];
  assign bus.Flush_Count = cnt_reg[1];
`else
  assign bus.Stall_Count = 16'd0;
  assign bus.Flush_Count = 16'd0;
`endif

endmodule

// File: tb/tb_inst_pipe_regs.sv
// Directed self-checking bench for inst_pipe_regs; statistics expectations
// follow HAZARD_STATS_EN when the bench is compiled with it.
module tb_inst_pipe_regs;

  localparam logic [31:0] NOP  = 32'h00000000;
  localparam logic [31:0] ADDI = 32'h20010001; // addi r1,r0,1
  localparam logic [31:0] ORI  = 32'h34020002; // ori  r2,r0,2
  localparam logic [31:0] ANDI = 32'h30230003; // andi r3,r1,3
  localparam logic [31:0] ADD4 = 32'h00222020; // add  r4,r1,r2
  localparam logic [31:0] LW5  = 32'h8C250000; // lw   r5,0(r1)
  localparam logic [31:0] ADD6 = 32'h00A23020; // add  r6,r5,r2
  localparam logic [31:0] LW0  = 32'h8C200000; // lw   r0,0(r1)
  localparam logic [31:0] ADD7 = 32'h00003820; // add  r7,r0,r0
  localparam logic [31:0] ORI5 = 32'h34650001; // ori  r5,r3,1
  localparam logic [31:0] SW5  = 32'hAC450000; // sw   r5,0(r2)
  localparam logic [31:0] BEQ  = 32'h10220003; // beq  r1,r2,3
  localparam logic [31:0] LW55 = 32'h8CA50000; // lw   r5,0(r5)

`ifdef HAZARD_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   n_stall = 0;
  int   n_flush = 0;
  logic [127:0] regs_exp;
  logic [127:0] regs_got;

  inst_pipe_regs_if bus ();

  inst_pipe_regs #(.NOP_INST(NOP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  assign regs_got = {bus.PR_IFID_Inst, bus.PR_IDEX_Inst, bus.PR_EXMEM_Inst, bus.PR_MEMWB_Inst};

  function automatic logic [15:0] exp_cnt(input int n);
    if (STATS == 0) return 16'd0;
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic feed(input logic [31:0] inst);
    bus.IF_Inst = inst;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.IF_Inst = ADDI;
    bus.Branch_Taken = 1'b0;
    bus.Global_Stall = 1'b0;
    #2;
    regs_exp = {NOP, NOP, NOP, NOP};
    checks++;
    if (regs_got !== regs_exp) begin
      errors++; $display("FAIL reset_regs: got %h expected %h", regs_got, regs_exp);
    end
    checks++;
    if ({bus.Stall_Count, bus.Flush_Count} !== 32'd0) begin
      errors++; $display("FAIL reset_counts: got %h/%h expected 0/0", bus.Stall_Count, bus.Flush_Count);
    end
    tick(); tick();
    checks++;
    if (regs_got !== regs_exp) begin
      errors++; $display("FAIL reset_held: got %h expected %h", regs_got, regs_exp);
    end
    @(negedge clock);
    reset = 1'b1;
    bus.IF_Inst = ORI;
    tick();
    regs_exp = {ORI, NOP, NOP, NOP};
    checks++;
    if (regs_got !== regs_exp) begin
      errors++; $display("FAIL reset_first_edge: got %h expected %h", regs_got, regs_exp);
    end
    $display("test_reset done");
  endtask

  task automatic test_straight();
    logic [31:0] seq [4];
    seq[0] = ADDI; seq[1] = ORI; seq[2] = ANDI; seq[3] = ADD4;
    for (int i = 0; i < 4; i++) begin
      feed(seq[i]);
      checks++;
      if (bus.PC_Hold !== 1'b0) begin
        errors++; $display("FAIL straight_pc_hold[%0d]: got %b expected 0", i, bus.PC_Hold);
      end
    end
    regs_exp = {ADD4, ANDI, ORI, ADDI};
    checks++;
    if (regs_got !== regs_exp) begin
      errors++; $display("FAIL straight_regs: got %h expected %h", regs_got, regs_exp);
    end
    $display("test_straight done");
  endtask

  task automatic test_load_use();
    feed(LW5);
    feed(ADD6);
    checks++;
    if ({bus.Load_Use, bus.PC_Hold} !== 2'b11) begin
      errors++; $display("FAIL lu_detect: got lu=%b hold=%b expected 1/1", bus.Load_Use, bus.PC_Hold);
    end
    feed(NOP);
    n_stall++;
    regs_exp = {ADD6, NOP, LW5, ADD4};
    checks++;
    if (regs_got !== regs_exp) begin
      errors++; $display("FAIL lu_stall_regs: got %h expected %h", regs_got, regs_exp);
    end
    checks++;
    if ({bus.Load_Use, bus.PC_Hold} !== 2'b00) begin
      errors++; $display("FAIL lu_cleared: got lu=%b hold=%b expected 0/0", bus.Load_Use, bus.PC_Hold);
    end
    checks++;
    if (bus.Stall_Count !== exp_cnt(n_stall)) begin
      errors++; $display("FAIL lu_stall_count: got %0d expected %0d", bus.Stall_Count, exp_cnt(n_stall));
    end
    $display("test_load_use done");
  endtask

  task automatic test_exclusions();
    feed(LW0);
    feed(ADD7);
    checks++;
    if (bus.Load_Use !== 1'b0) begin
      errors++; $display("FAIL excl_r0: got %b expected 0", bus.Load_Use);
    end
    feed(LW5);
    feed(ORI5);
    checks++;
    if (bus.Load_Use !== 1'b0) begin
      errors++; $display("FAIL excl_ori_rt: got %b expected 0", bus.Load_Use);
    end
    feed(LW5);
    feed(SW5);
    checks++;
    if (bus.Load_Use !== 1'b1) begin
      errors++; $display("FAIL sw_rt_use: got %b expected 1", bus.Load_Use);
    end
    feed(NOP);
    n_stall++;
    checks++;
    if ({bus.PR_IFID_Inst, bus.PR_IDEX_Inst} !== {SW5, NOP}) begin
      errors++; $display("FAIL sw_stall_regs: got %h/%h expected %h/%h", bus.PR_IFID_Inst, bus.PR_IDEX_Inst, SW5, NOP);
    end
    checks++;
    if (bus.Stall_Count !== exp_cnt(n_stall)) begin
      errors++; $display("FAIL sw_stall_count: got %0d expected %0d", bus.Stall_Count, exp_cnt(n_stall));
    end
    $display("test_exclusions done");
  endtask

  task automatic test_flush_beats_stall();
    feed(BEQ);
    feed(LW5);
    feed(ADD6);
    bus.Branch_Taken = 1'b1;
    #1;
    checks++;
    if ({bus.Load_Use, bus.PC_Hold} !== 2'b10) begin
      errors++; $display("FAIL flush_pc_hold: got lu=%b hold=%b expected 1/0", bus.Load_Use, bus.PC_Hold);
    end
    feed(ANDI);
    n_flush++;
    bus.Branch_Taken = 1'b0;
    regs_exp = {NOP, NOP, NOP, BEQ};
    checks++;
    if (regs_got !== regs_exp) begin
      errors++; $display("FAIL flush_regs: got %h expected %h", regs_got, regs_exp);
    end
    checks++;
    if ({bus.Stall_Count, bus.Flush_Count} !== {exp_cnt(n_stall), exp_cnt(n_flush)}) begin
      errors++; $display("FAIL flush_counts: got %0d/%0d expected %0d/%0d", bus.Stall_Count, bus.Flush_Count, exp_cnt(n_stall), exp_cnt(n_flush));
    end
    $display("test_flush_beats_stall done");
  endtask

  task automatic test_freeze();
    feed(BEQ);
    feed(ADDI);
    feed(ORI);
    bus.Global_Stall = 1'b1;
    bus.Branch_Taken = 1'b1;
    bus.IF_Inst = ANDI;
    #1;
    checks++;
    if (bus.PC_Hold !== 1'b1) begin
      errors++; $display("FAIL freeze_pc_hold: got %b expected 1", bus.PC_Hold);
    end
    regs_exp = {ORI, ADDI, BEQ, NOP};
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (regs_got !== regs_exp) begin
        errors++; $display("FAIL freeze_regs[%0d]: got %h expected %h", i, regs_got, regs_exp);
      end
    end
    checks++;
    if ({bus.Stall_Count, bus.Flush_Count} !== {exp_cnt(n_stall), exp_cnt(n_flush)}) begin
      errors++; $display("FAIL freeze_counts: got %0d/%0d expected %0d/%0d", bus.Stall_Count, bus.Flush_Count, exp_cnt(n_stall), exp_cnt(n_flush));
    end
    bus.Global_Stall = 1'b0;
    tick();
    n_flush++;
    bus.Branch_Taken = 1'b0;
    regs_exp = {NOP, NOP, NOP, BEQ};
    checks++;
    if (regs_got !== regs_exp) begin
      errors++; $display("FAIL release_flush: got %h expected %h", regs_got, regs_exp);
    end
    tick();
    regs_exp = {ANDI, NOP, NOP, NOP};
    checks++;
    if (regs_got !== regs_exp) begin
      errors++; $display("FAIL flush_once: got %h expected %h", regs_got, regs_exp);
    end
    checks++;
    if (bus.Flush_Count !== exp_cnt(n_flush)) begin
      errors++; $display("FAIL release_flush_count: got %0d expected %0d", bus.Flush_Count, exp_cnt(n_flush));
    end
    $display("test_freeze done");
  endtask

  task automatic test_async_reset();
    feed(LW5);
    feed(ADD6);
    checks++;
    if (bus.Load_Use !== 1'b1) begin
      errors++; $display("FAIL pre_reset_lu: got %b expected 1", bus.Load_Use);
    end
    #2;
    reset = 1'b0;
    n_stall = 0;
    n_flush = 0;
    #1;
    regs_exp = {NOP, NOP, NOP, NOP};
    checks++;
    if (regs_got !== regs_exp) begin
      errors++; $display("FAIL async_reset_regs: got %h expected %h", regs_got, regs_exp);
    end
    checks++;
    if ({bus.Load_Use, bus.Stall_Count, bus.Flush_Count} !== 33'd0) begin
      errors++; $display("FAIL async_reset_state: got lu=%b %0d/%0d expected 0 0/0", bus.Load_Use, bus.Stall_Count, bus.Flush_Count);
    end
    @(negedge clock);
    reset = 1'b1;
    feed(ADDI);
    regs_exp = {ADDI, NOP, NOP, NOP};
    checks++;
    if (regs_got !== regs_exp) begin
      errors++; $display("FAIL post_reset_edge: got %h expected %h", regs_got, regs_exp);
    end
    $display("test_async_reset done");
  endtask

  task automatic test_saturation();
    int n_iter;
    n_iter = (STATS != 0) ? 65537 : 8;
    feed(LW55);
    feed(LW55);
    // lw r5,0(r5) behind itself re-arms a load-use after every bubble
    for (int i = 0; i < n_iter; i++) begin
      tick();
      n_stall++;
      tick();
    end
    checks++;
    if (bus.Stall_Count !== exp_cnt(n_stall)) begin
      errors++; $display("FAIL stall_saturate: got %h expected %h", bus.Stall_Count, exp_cnt(n_stall));
    end
    checks++;
    if (bus.Flush_Count !== exp_cnt(n_flush)) begin
      errors++; $display("FAIL sat_flush_count: got %h expected %h", bus.Flush_Count, exp_cnt(n_flush));
    end
    $display("test_saturation done: %0d stalls", n_stall);
  endtask

  initial begin
    test_reset();
    test_straight();
    test_load_use();
    test_exclusions();
    test_flush_beats_stall();
    test_freeze();
    test_async_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_pipe_regs.md
INST_PIPE_REGS -- requirements
Module: inst_pipe_regs

Interface
REQ-001 The block SHALL have parameter NOP_INST, default 32'h00000000 (SLL r0,r0,0), the bubble word.
REQ-002 The block SHALL have port clock, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port IF_Inst, input, 32, the fetched instruction word.
REQ-005 The block SHALL have port Branch_Taken, input, 1, asserted while PR_EXMEM_Inst holds a BEQ whose condition is true.
REQ-006 The block SHALL have port Global_Stall, input, 1, a freeze of the whole pipeline (memory wait).
REQ-007 The block SHALL have ports PR_IFID_Inst, PR_IDEX_Inst, PR_EXMEM_Inst and PR_MEMWB_Inst, each output, 32, the stage instruction registers.
REQ-008 The block SHALL have port PC_Hold, output, 1, a combinational instruction to hold the PC and fetch.
REQ-009 The block SHALL have port Load_Use, output, 1, the combinational load-use hazard flag.
REQ-010 The block SHALL have ports Stall_Count and Flush_Count, each output, 16, hazard statistics (see Configuration).

Function
REQ-011 Load_Use SHALL be 1 iff opcode(IDEX)=OP_LW, rt(IDEX)!=0 and either condition below holds:
- rt(IDEX)=rs(IFID);
- rt(IDEX)=rt(IFID) and opcode(IFID) is OP_SPECIAL, OP_BEQ or OP_SW.
REQ-012 On each rising edge with Global_Stall=1, all four stage registers SHALL hold; Branch_Taken and Load_Use are ignored on that edge.
REQ-013 On an edge with Global_Stall=0 and Branch_Taken=1 (flush), IFID, IDEX and EXMEM SHALL load NOP_INST and MEMWB SHALL load the old EXMEM (the branch).
REQ-014 On an edge with Global_Stall=0, Branch_Taken=0 and Load_Use=1 (stall), IFID SHALL hold, IDEX SHALL load NOP_INST, EXMEM<=IDEX and MEMWB<=EXMEM.
REQ-015 Otherwise, the registers SHALL shift: IFID<=IF_Inst, IDEX<=IFID, EXMEM<=IDEX, MEMWB<=EXMEM.
REQ-016 Priority SHALL be Global_Stall > Branch_Taken > Load_Use; a simultaneous flush and load-use SHALL resolve as a flush only.
REQ-017 PC_Hold SHALL equal Global_Stall | (Load_Use & ~Branch_Taken).
REQ-018 Latency SHALL be one edge per stage; an instruction presented on IF_Inst SHALL reach PR_MEMWB_Inst after 4 unfrozen, unstalled edges.
REQ-019 A stall SHALL last exactly one edge per load-use pair, because the bubble clears the LW from IDEX.

Reset
REQ-020 While reset=0, all four stage registers SHALL be NOP_INST immediately, independent of clock.
REQ-021 While reset=0, Stall_Count and Flush_Count SHALL be 0.
REQ-022 After reset is released, the first rising edge SHALL behave per REQ-012..REQ-016; reset asserted mid-stall or mid-flush SHALL discard all in-flight state.

Configuration
REQ-023 With macro HAZARD_STATS_EN defined, Stall_Count SHALL increment on each stall edge (REQ-014) and Flush_Count on each flush edge (REQ-013), both saturating at 16'hFFFF with no wrap.
REQ-024 Without HAZARD_STATS_EN, Stall_Count and Flush_Count SHALL be tied to 0, no counter logic SHALL be present, and the ports SHALL remain.

Verification
REQ-025 The bench SHALL cover straight-line flow: feed ADDI, ORI, ANDI, ADD on 4 edges -> PR_MEMWB_Inst=ADDI and PR_IFID_Inst=ADD after edge 4; PC_Hold=0 throughout.
REQ-026 The bench SHALL cover load-use: IDEX=LW r5,0(r1), IFID=ADD r6,r5,r2 -> Load_Use=1 and PC_Hold=1; next edge IDEX=NOP, IFID=ADD, EXMEM=LW; Load_Use=0 after; Stall_Count=1 (HAZARD_STATS_EN).
REQ-027 The bench SHALL cover the r0 and ORI-rt exclusions: IDEX=LW r0,..., IFID reads r0 -> Load_Use=0; IDEX=LW r5, IFID=ORI r5,r3,1 (rt=5 is a destination) -> Load_Use=0.
REQ-028 The bench SHALL cover flush beating stall: EXMEM=BEQ, Branch_Taken=1, Load_Use=1 same cycle -> next edge IFID/IDEX/EXMEM=NOP, MEMWB=BEQ, PC_Hold=0 that cycle; Flush_Count+1 and Stall_Count unchanged.
REQ-029 The bench SHALL cover freeze: Global_Stall=1 for 3 edges with Branch_Taken=1 -> registers unchanged and no counts; on release the flush applies once.
REQ-030 The bench SHALL cover async reset mid-operation and saturation: drop reset between edges -> all stage outputs NOP_INST at once; force 65537 stalls -> Stall_Count=16'hFFFF.
